// File: rtl/disp7_scan.sv
// disp7_scan: four-digit common-anode 7-segment scanner for the 24-hour clock.
// A prescaler steps a slot index through the four digits. A frame-boundary
// snapshot keeps each frame tear-free. Every slot opens with a dead window
// that turns all anodes off to suppress ghosting. All outputs are registered,
// so nothing passes combinationally from the inputs to the pins.
module disp7_scan #(
   parameter int SCAN_DIV    = 250,
   parameter int BLANK_CYC   = 8,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] M0,
   input  logic [3:0] M1,
   input  logic [3:0] H0,
   input  logic [1:0] H1,
   input  logic       Dots,
   input  logic       lz_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic [1:0] digit_idx
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

   // XOR masks that map active-high internal levels onto the pin polarity.
   localparam logic [6:0] SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_MASK  = (SEG_ACT_LOW != 0);
   localparam logic [3:0] AN_MASK  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

   // Internal code that the decoder renders as an unlit digit.
   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Scan state.
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       idx_reg, idx_next;

   // Frame snapshot of the inputs.
   logic [3:0] sh_m0_reg, sh_m0_next;
   logic [3:0] sh_m1_reg, sh_m1_next;
   logic [3:0] sh_h0_reg, sh_h0_next;
   logic [1:0] sh_h1_reg, sh_h1_next;
   logic       sh_dots_reg, sh_dots_next;
   logic       sh_lz_reg, sh_lz_next;

   // Output registers, held at pin polarity.
   logic [6:0] seg_reg, seg_next;
   logic       dp_reg, dp_next;
   logic [3:0] an_reg, an_next;
   logic [1:0] didx_reg, didx_next;

   // Decode helpers.
   logic       slot_wrap;
   logic       frame_end;
   logic       win_active;
   logic [3:0] h1_code;
   logic [3:0] digit_code;
   logic [3:0] an_hot;

   // Active-high g..a pattern for one 4-bit digit code.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         4'hF:    s = 7'b0000000;   // blink code: dark digit
         default: s = 7'b1000000;   // A..E: dash flags illegal BCD
      endcase
      return s;
   endfunction

   // State register: prescaler, slot index and frame snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         idx_reg     <= 2'd0;
         sh_m0_reg   <= 4'd0;
         sh_m1_reg   <= 4'd0;
         sh_h0_reg   <= 4'd0;
         sh_h1_reg   <= 2'd0;
         sh_dots_reg <= 1'b0;
         sh_lz_reg   <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         sh_m0_reg   <= sh_m0_next;
         sh_m1_reg   <= sh_m1_next;
         sh_h0_reg   <= sh_h0_next;
         sh_h1_reg   <= sh_h1_next;
         sh_dots_reg <= sh_dots_next;
         sh_lz_reg   <= sh_lz_next;
      end
   end

   // Next state: wrap the prescaler, step the slot, and snapshot on the frame boundary.
   always_comb begin
      slot_wrap    = (cnt_reg == CNT_LAST);
      frame_end    = slot_wrap && (idx_reg == 2'd3);
      cnt_next     = slot_wrap ? '0 : cnt_reg + 1'b1;
      idx_next     = slot_wrap ? idx_reg + 2'd1 : idx_reg;
      sh_m0_next   = sh_m0_reg;
      sh_m1_next   = sh_m1_reg;
      sh_h0_next   = sh_h0_reg;
      sh_h1_next   = sh_h1_reg;
      sh_dots_next = sh_dots_reg;
      sh_lz_next   = sh_lz_reg;
      if (frame_end) begin
         sh_m0_next   = M0;
         sh_m1_next   = M1;
         sh_h0_next   = H0;
         sh_h1_next   = H1;
         sh_dots_next = Dots;
         sh_lz_next   = lz_en;
      end
   end

   // H1 is two bits wide. Code 3 blinks dark rather than showing a dash.
   // Leading-zero suppression also turns a zero tens-hour dark.
   always_comb begin
      h1_code = {2'b00, sh_h1_reg};
      if (sh_h1_reg == 2'd3) begin
         h1_code = BLANK_CODE;
      end else if ((sh_h1_reg == 2'd0) && sh_lz_reg) begin
         h1_code = BLANK_CODE;
      end
   end

   // Select the snapshot digit for the current slot.
   always_comb begin
      case (idx_reg)
         2'd0:    digit_code = sh_m0_reg;
         2'd1:    digit_code = sh_m1_reg;
         2'd2:    digit_code = sh_h0_reg;
         default: digit_code = h1_code;
      endcase
   end

   // Dead time at the start of every slot keeps the previous digit's segments
   // from ghosting onto the next anode.
   assign win_active = (cnt_reg >= CNT_BLANK);

   // One-hot anode enable for the current slot, only inside the active window.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_an
         assign an_hot[gi] = win_active && (idx_reg == 2'(gi));
      end
   endgenerate

   // Output logic: compute pin-polarity levels from the current count, slot and snapshot.
   always_comb begin
      seg_next  = SEG_MASK;
      dp_next   = DP_MASK;
      an_next   = AN_MASK ^ an_hot;
      didx_next = idx_reg;
      if (win_active) begin
         seg_next = SEG_MASK ^ bcd_to_seg(digit_code);
         dp_next  = DP_MASK ^ ((idx_reg == 2'd2) && sh_dots_reg);
      end
   end

   // Output register: one cycle of latency, and everything off during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_reg  <= SEG_MASK;
         dp_reg   <= DP_MASK;
         an_reg   <= AN_MASK;
         didx_reg <= 2'd0;
      end else begin
         seg_reg  <= seg_next;
         dp_reg   <= dp_next;
         an_reg   <= an_next;
         didx_reg <= didx_next;
      end
   end

   assign seg       = seg_reg;
   assign dp        = dp_reg;
   assign an        = an_reg;
   assign digit_idx = didx_reg;

endmodule

// File: tb/tb_disp7_scan.sv
// Scoreboard bench for disp7_scan (SCAN_DIV=10, BLANK_CYC=2, active-low pins).
// The reference process knows only the display rules. It tracks the position
// within a frame as a cycle count and the last frame-boundary snapshot. On
// every clock it pushes the expected pins. The monitor pops an entry and
// compares it on the falling edge.
module tb_disp7_scan;

   localparam int DIV   = 10;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * DIV;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic [1:0] idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] M0 = 4'd0, M1 = 4'd0, H0 = 4'd0;
   logic [1:0] H1 = 2'd0;
   logic       Dots = 1'b0, lz_en = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic [1:0] digit_idx;

   int n_chk  = 0;
   int n_fail = 0;
   int n_txn  = 0;

   exp_t exp_q[$];
   bit   started = 0;

   // Shadow of the inputs, as the reference model sees it.
   int         pos;
   logic [3:0] r_m0, r_m1, r_h0;
   logic [1:0] r_h1;
   logic       r_dots, r_lz;
   logic [6:0] seg_tbl [16];

   disp7_scan #(
      .SCAN_DIV(DIV), .BLANK_CYC(BLANK), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .M0(M0), .M1(M1), .H0(H0), .H1(H1),
      .Dots(Dots), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
      .digit_idx(digit_idx)
   );

   always #5 clk = ~clk;

   initial begin
      seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
   end

   // Expected pins at frame position p, from the display rules.
   function automatic exp_t model_out(input int p);
      exp_t e;
      int   slot, c, val;
      slot = (p / DIV) % 4;
      c    = p % DIV;
      e.idx = 2'(slot);
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.an  = 4'hF;
      if (c >= BLANK) begin
         case (slot)
            0: val = int'(r_m0);
            1: val = int'(r_m1);
            2: val = int'(r_h0);
            default: begin
               if (r_h1 == 2'd3 || (r_h1 == 2'd0 && r_lz)) val = 15;
               else val = int'(r_h1);
            end
         endcase
         e.seg = ~seg_tbl[val];
         e.an  = ~(4'(1) << slot);
         e.dp  = ~((slot == 2) && r_dots);
      end
      return e;
   endfunction

   // Reference model: one expected entry per clock edge.
   always @(posedge clk) begin
      exp_t e;
      if (rst) begin
         pos = 0;
         r_m0 = 0; r_m1 = 0; r_h0 = 0; r_h1 = 0; r_dots = 0; r_lz = 0;
         e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, idx: 2'd0};
      end else begin
         e = model_out(pos);
         pos = pos + 1;
         if (pos % FRAME == 0) begin
            r_m0 = M0; r_m1 = M1; r_h0 = H0; r_h1 = H1;
            r_dots = Dots; r_lz = lz_en;
         end
      end
      exp_q.push_back(e);
   end

   // Monitor: compare each registered output against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      int   zeros;
      if (exp_q.size() == 0) begin
         if (started) begin
            n_chk++; n_fail++;
            $display("FAIL sb_empty: DUT output with no expected entry at %0t", $time);
         end
      end else begin
         e = exp_q.pop_front();
         started = 1;
         n_txn++;
         $display("txn %0d: an=%b seg=%b dp=%b idx=%0d | exp an=%b seg=%b dp=%b idx=%0d",
                  n_txn, an, seg, dp, digit_idx, e.an, e.seg, e.dp, e.idx);
         n_chk++;
         if (an !== e.an) begin
            n_fail++;
            $display("FAIL an: got %b expected %b (txn %0d)", an, e.an, n_txn);
         end
         n_chk++;
         if (seg !== e.seg) begin
            n_fail++;
            $display("FAIL seg: got %b expected %b (txn %0d)", seg, e.seg, n_txn);
         end
         n_chk++;
         if (dp !== e.dp) begin
            n_fail++;
            $display("FAIL dp: got %b expected %b (txn %0d)", dp, e.dp, n_txn);
         end
         n_chk++;
         if (digit_idx !== e.idx) begin
            n_fail++;
            $display("FAIL digit_idx: got %0d expected %0d (txn %0d)", digit_idx, e.idx, n_txn);
         end
         zeros = 0;
         for (int i = 0; i < 4; i++) if (an[i] == 1'b0) zeros++;
         n_chk++;
         if (zeros > 1) begin
            n_fail++;
            $display("FAIL an_onehot: got %b expected at most one low bit", an);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_inputs();
      M0 = 4'($urandom); M1 = 4'($urandom); H0 = 4'($urandom);
      H1 = 2'($urandom); Dots = 1'($urandom); lz_en = 1'($urandom);
   endtask

   // Wait, with a bound, until the DUT is in the given slot with the given anodes.
   task automatic wait_slot(input logic [1:0] s, input logic [3:0] a);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (digit_idx == s && an == a) return;
      end
      n_chk++; n_fail++;
      $display("FAIL wait_slot: got idx=%0d an=%b expected idx=%0d an=%b", digit_idx, an, s, a);
   endtask

   task automatic set_frame(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] h0,
                            input logic [1:0] h1, input logic d, input logic lz);
      M0 = m0; M1 = m1; H0 = h0; H1 = h1; Dots = d; lz_en = lz;
   endtask

   initial begin
      // Reset held with changing inputs.
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_inputs();
         cyc(1);
      end
      rst = 1'b0;

      // Free-run scan with inputs churning every cycle.
      for (int i = 0; i < 80; i++) begin
         rand_inputs();
         cyc(1);
      end

      // Decode sweep on slot 0, one value per frame.
      for (int v = 0; v < 16; v++) begin
         set_frame(4'(v), 4'hF, 4'hF, 2'd3, 1'b0, 1'b0);
         cyc(FRAME);
      end
      cyc(FRAME);

      // Snapshot: 3 latched at the boundary, changed to 7 inside slot 1.
      set_frame(4'd1, 4'd3, 4'd5, 2'd1, 1'b1, 1'b0);
      wait_slot(2'd2, 4'b1011);
      wait_slot(2'd1, 4'b1101);
      M1 = 4'd7;
      cyc(2 * FRAME);

      // H1 cases: leading zero on/off, 2, blink code.
      set_frame(4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1); cyc(2 * FRAME);
      set_frame(4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0); cyc(2 * FRAME);
      set_frame(4'd3, 4'd5, 4'd3, 2'd2, 1'b0, 1'b1); cyc(2 * FRAME);
      set_frame(4'd3, 4'd5, 4'd3, 2'd3, 1'b0, 1'b0); cyc(2 * FRAME);

      // Dots on, then off.
      set_frame(4'd9, 4'd5, 4'd2, 2'd1, 1'b1, 1'b0); cyc(2 * FRAME);
      set_frame(4'd9, 4'd5, 4'd2, 2'd1, 1'b0, 1'b0); cyc(2 * FRAME);

      // Reset pulse mid-slot 2 with Dots showing.
      Dots = 1'b1;
      cyc(2 * FRAME);
      wait_slot(2'd2, 4'b1011);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(2 * FRAME);

      // Random soak with occasional reset pulses.
      for (int i = 0; i < 1500; i++) begin
         if ((i % 7) == 0) rand_inputs();
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0;
      cyc(3);
      #1;

      n_chk++;
      if (exp_q.size() > 1) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending entries expected at most 1", exp_q.size());
      end
      n_chk++;
      if (n_txn < 2000) begin
         n_fail++;
         $display("FAIL txn_count: got %0d expected at least 2000", n_txn);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/disp7_scan.md
Name: disp7_scan

Overview:
- Downstream display stage of the 24-hour clock core.
- Consumes the four BCD digit buses (M0, M1, H0, H1) and the Dots blink line, which run at 1 MHz.
- Drives a 4-digit common-anode multiplexed 7-segment display: prescaled digit scan, per-frame input snapshot, BCD-to-segment decode, blink-code blanking, ghost-suppression dead time and colon/decimal-point control.

Parameters:
- SCAN_DIV, 250: clk cycles per digit slot (1 MHz gives a 4 kHz slot and a 1 kHz frame).
- BLANK_CYC, 8: dead cycles at the start of each slot with all anodes off. Legal range 1 to SCAN_DIV-2.
- SEG_ACT_LOW, 1: 1 means seg and dp are active-low; 0 means active-high.
- AN_ACT_LOW, 1: 1 means an is active-low; 0 means active-high.

Ports:
- clk, input, 1: system clock, 1 MHz. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- M0, input, 4: minutes units, BCD. 4'hF is the blink/blank code.
- M1, input, 4: minutes tens, BCD. 4'hF is the blink/blank code.
- H0, input, 4: hours units, BCD. 4'hF is the blink/blank code.
- H1, input, 2: hours tens, 0 to 2. 2'b11 is the blink/blank code.
- Dots, input, 1: colon blink level.
- lz_en, input, 1: 1 enables leading-zero blanking of H1.
- seg, output, 7: segments, bit 6..0 = g,f,e,d,c,b,a.
- dp, output, 1: decimal point / colon segment.
- an, output, 4: anode enables. an[0]=M0 (rightmost), an[1]=M1, an[2]=H0, an[3]=H1.
- digit_idx, output, 2: index of the current slot.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - cnt=0, idx=0, all shadow registers 0.
  - an all inactive; seg all off; dp off; digit_idx=0.
  - "Off" and "inactive" mean the polarity-adjusted levels.
- Prescaler:
  - cnt runs 0 to SCAN_DIV-1, then wraps to 0.
  - On each wrap, idx advances 0→1→2→3→0.
- Snapshot:
  - When cnt wraps with idx=3 (frame boundary), capture M0, M1, H0, H1, Dots and lz_en into shadow registers.
  - Mid-frame input changes are ignored until the next frame boundary. This prevents tearing.
  - The first frame after reset displays shadow=0.
- Output timing:
  - All outputs are registered from the current (cnt, idx, shadow) values, giving one clk of latency.
  - digit_idx follows idx with the same one-cycle latency.
- Slot window:
  - While cnt < BLANK_CYC: an is all inactive, seg is all off, dp is off.
  - While cnt >= BLANK_CYC: an[idx] is active, other anodes are inactive, seg = decode(shadow digit[idx]).
- Decode, shown as active-high g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 4'hA to 4'hE = 1000000 (dash; error indicator for illegal BCD)
  - 4'hF = 0000000 (blank)
- Inversion: seg and dp are inverted when SEG_ACT_LOW=1; an is inverted when AN_ACT_LOW=1.
- H1 slot:
  - H1 is zero-extended to 4 bits.
  - H1=3 is the blink code and is blank, not a dash.
  - H1=0 with shadow lz_en=1 is blank.
- dp: active only in slot 2 (H0), inside the active window, when shadow Dots=1. Off in all other cases.
- Reset mid-operation: all state returns to reset values on the next edge. Scanning restarts at slot 0 with the blank window.
- Digit slot order is fixed. No combinational path exists from inputs to outputs.

Test Plan:
All tests use SCAN_DIV=10, BLANK_CYC=2, SEG_ACT_LOW=1, AN_ACT_LOW=1.
1. Reset: hold rst=1 for 5 cycles with arbitrary inputs → an=1111, seg=1111111, dp=1, digit_idx=0 on every cycle. Release rst → an stays 1111 for 2+1 cycles, then an=1110.
2. Scan timing: free-run for 80 cycles → an repeats 1111×2, 1110×8, 1111×2, 1101×8, 1111×2, 1011×8, 1111×2, 0111×8. Period is 40 cycles; an never has two low bits at once.
3. Decode sweep: set M0=0..15, one value per frame, M1=H0=4'hF, H1=3 → slot 0 seg shows 1000000 for 0, 0000000 for 8, 1111111 for F, 0111111 for A to E. Slots 1 to 3 stay 1111111 while their anode is low.
4. Snapshot: M1=3 at the frame boundary, change to M1=7 during slot 1's active window → slot 1 shows 0110000 (3) for the rest of that frame and 1111000 (7) from the next frame.
5. H1 blanking:
   - H1=0, lz_en=1 → slot 3 seg=1111111.
   - H1=0, lz_en=0 → slot 3 seg=1000000.
   - H1=2 → slot 3 seg=0100100.
   - H1=3 → slot 3 seg=1111111.
6. Dots: Dots=1 → dp=0 only on the 8 active cycles of slot 2; dp=1 elsewhere. Dots=0 → dp=1 always. Assert rst for 1 cycle mid-slot 2 → next cycle an=1111 and dp=1, and scanning restarts from slot 0.
